// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared state encodings and constants for the hazard stall controller
package hazard_stall_ctrl_pkg;

    // Default register address width of the RV32 register file
    localparam int REG_ADDR_W_DEF = 5;

    // x0 is hardwired to zero and never creates a dependency
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        HAZ_RUN = 2'd0,
        HAZ_LU  = 2'd1,
        HAZ_MD  = 2'd2,
        HAZ_MEM = 2'd3
    } haz_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_lu_compare.sv
// rtl/hazard_stall_ctrl_lu_compare.sv - combinational load-use dependency detector (haz_lu_compare)
module haz_lu_compare
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_addr1,
    input  logic [REG_ADDR_W-1:0] id_addr2,
    input  logic                  id_op1_sel,
    input  logic                  id_op2_sel,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] ex_w_addr,
    input  logic                  ex_mem_read,
    output logic                  lu_haz
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic rs1_dep;
    logic rs2_dep;

    // An operand only depends on the load if it is actually read from the register file
    assign rs1_dep = !id_op1_sel && (id_addr1 == ex_w_addr);
    assign rs2_dep = !id_op2_sel && (id_addr2 == ex_w_addr);
    assign lu_haz  = id_valid && ex_mem_read && (ex_w_addr != ZERO_ADDR) && (rs1_dep || rs2_dep);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/bubble controller; optional perf counters via HAZ_PERF_CNT_EN
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int LOAD_STALL_CYC = 1,
    parameter int MULDIV_CYC     = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] ID_ADDR1,
    input  logic [REG_ADDR_W-1:0] ID_ADDR2,
    input  logic                  ID_OP1_SEL,
    input  logic                  ID_OP2_SEL,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] EX_W_ADDR,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_MULDIV,
    input  logic                  MEM_BUSY,
    output logic                  PC_WE,
    output logic                  IF_ID_WE,
    output logic                  ID_EX_WE,
    output logic                  ID_EX_BUBBLE,
    output logic                  EX_MEM_WE,
    output logic                  EX_MEM_BUBBLE,
`ifdef HAZ_PERF_CNT_EN
    output logic                  MEM_WB_BUBBLE,
    output logic [31:0]           LU_STALL_CNT,
    output logic [31:0]           MD_STALL_CNT,
    output logic [31:0]           MEM_STALL_CNT
`else
    output logic                  MEM_WB_BUBBLE
`endif
);

    localparam int CNT_MAX = max_int(LOAD_STALL_CYC, MULDIV_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reload values only matter when the matching multi-cycle path exists
    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'((MULDIV_CYC > 1) ? MULDIV_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'((LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0);
    localparam bit MD_STALLS = (MULDIV_CYC > 1);
    localparam bit MD_LONG   = (MULDIV_CYC > 2);
    localparam bit LU_LONG   = (LOAD_STALL_CYC > 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    haz_state_t       state;
    haz_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu_haz;

    haz_lu_compare #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_compare (
        .id_addr1    (ID_ADDR1),
        .id_addr2    (ID_ADDR2),
        .id_op1_sel  (ID_OP1_SEL),
        .id_op2_sel  (ID_OP2_SEL),
        .id_valid    (ID_VALID),
        .ex_w_addr   (EX_W_ADDR),
        .ex_mem_read (EX_MEM_READ),
        .lu_haz      (lu_haz)
    );

    // Mealy output decode and next-state selection, priority MEM_BUSY > MUL/DIV > load-use
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        PC_WE         = 1'b1;
        IF_ID_WE      = 1'b1;
        ID_EX_WE      = 1'b1;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_WE     = 1'b1;
        EX_MEM_BUBBLE = 1'b0;
        MEM_WB_BUBBLE = 1'b0;
        if (RESET) begin
            PC_WE         = 1'b0;
            IF_ID_WE      = 1'b0;
            ID_EX_WE      = 1'b0;
            ID_EX_BUBBLE  = 1'b1;
            EX_MEM_WE     = 1'b0;
            EX_MEM_BUBBLE = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
        end else if (MEM_BUSY) begin
            // Whole pipe freezes; a pending MUL/DIV or load-use stall resumes afterwards
            PC_WE         = 1'b0;
            IF_ID_WE      = 1'b0;
            ID_EX_WE      = 1'b0;
            EX_MEM_WE     = 1'b0;
            MEM_WB_BUBBLE = 1'b1;
            if (state == HAZ_RUN) begin
                state_nxt = HAZ_MEM;
            end
        end else begin
            case (state)
                HAZ_MD: begin
                    if (cnt != '0) begin
                        PC_WE         = 1'b0;
                        IF_ID_WE      = 1'b0;
                        ID_EX_WE      = 1'b0;
                        EX_MEM_BUBBLE = 1'b1;
                        cnt_nxt       = cnt - CNT_ONE;
                    end else begin
                        // Result leaves EX this cycle; EX_MULDIV is still high and must be ignored
                        state_nxt = HAZ_RUN;
                    end
                end
                HAZ_LU: begin
                    // The load has already moved on, so the stall no longer depends on lu_haz
                    PC_WE        = 1'b0;
                    IF_ID_WE     = 1'b0;
                    ID_EX_BUBBLE = 1'b1;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end else begin
                        state_nxt = HAZ_RUN;
                    end
                end
                default: begin
                    // RUN, or MEM_WAIT just released: evaluate hazards as a normal run cycle
                    state_nxt = HAZ_RUN;
                    if (EX_MULDIV && MD_STALLS) begin
                        PC_WE         = 1'b0;
                        IF_ID_WE      = 1'b0;
                        ID_EX_WE      = 1'b0;
                        EX_MEM_BUBBLE = 1'b1;
                        cnt_nxt       = MD_RELOAD;
                        if (MD_LONG) begin
                            state_nxt = HAZ_MD;
                        end
                    end else if (lu_haz) begin
                        PC_WE        = 1'b0;
                        IF_ID_WE     = 1'b0;
                        ID_EX_BUBBLE = 1'b1;
                        if (LU_LONG) begin
                            cnt_nxt   = LU_RELOAD;
                            state_nxt = HAZ_LU;
                        end
                    end
                end
            endcase
        end
    end

    // State and stall counter registers; MEM_BUSY leaves cnt untouched via cnt_nxt
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= HAZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic lu_cause;
    logic md_cause;
    logic mem_cause;

    // Each output signature identifies exactly one active stall cause
    assign lu_cause  = !RESET && !MEM_BUSY && ID_EX_BUBBLE;
    assign md_cause  = !RESET && !MEM_BUSY && EX_MEM_BUBBLE;
    assign mem_cause = !RESET && MEM_BUSY;

    // Saturating per-cause stall cycle counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LU_STALL_CNT  <= '0;
            MD_STALL_CNT  <= '0;
            MEM_STALL_CNT <= '0;
        end else begin
            if (lu_cause && (LU_STALL_CNT != 32'hFFFF_FFFF)) begin
                LU_STALL_CNT <= LU_STALL_CNT + 32'd1;
            end
            if (md_cause && (MD_STALL_CNT != 32'hFFFF_FFFF)) begin
                MD_STALL_CNT <= MD_STALL_CNT + 32'd1;
            end
            if (mem_cause && (MEM_STALL_CNT != 32'hFFFF_FFFF)) begin
                MEM_STALL_CNT <= MEM_STALL_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed plus randomized check of hazard_stall_ctrl against a stall-budget model
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] a1 = '0, a2 = '0, wa = '0;
    logic       op1 = 1'b0, op2 = 1'b0, vld = 1'b0, mr = 1'b0, md = 1'b0, busy = 1'b0;
    logic [6:0] obs [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Instance k: {LOAD_STALL_CYC, MULDIV_CYC}
    int lcyc [3] = '{1, 3, 2};
    int mcyc [3] = '{4, 2, 1};

    // {PC_WE, IF_ID_WE, ID_EX_WE, ID_EX_BUBBLE, EX_MEM_WE, EX_MEM_BUBBLE, MEM_WB_BUBBLE}
    localparam logic [6:0] IDLE_V = 7'b1110100;
    localparam logic [6:0] RST_V  = 7'b0001011;
    localparam logic [6:0] MEM_V  = 7'b0000001;
    localparam logic [6:0] MD_V   = 7'b0000110;
    localparam logic [6:0] LU_V   = 7'b0011100;

    // Model: remaining freeze cycles of the active stall, plus a pending MUL/DIV release cycle
    int md_left [3] = '{0, 0, 0};
    int lu_left [3] = '{0, 0, 0};
    bit rel     [3] = '{0, 0, 0};
    int n_md    [3];
    int n_lu    [3];
    bit n_rel   [3];

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] lu_c [3], md_c [3], mem_c [3];
    longint exp_lu [3] = '{0, 0, 0};
    longint exp_md [3] = '{0, 0, 0};
    longint exp_mem [3] = '{0, 0, 0};
`endif

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYC(1), .MULDIV_CYC(4)) dut0 (
        .CLK(clk), .RESET(rst), .ID_ADDR1(a1), .ID_ADDR2(a2), .ID_OP1_SEL(op1), .ID_OP2_SEL(op2),
        .ID_VALID(vld), .EX_W_ADDR(wa), .EX_MEM_READ(mr), .EX_MULDIV(md), .MEM_BUSY(busy),
        .PC_WE(obs[0][6]), .IF_ID_WE(obs[0][5]), .ID_EX_WE(obs[0][4]), .ID_EX_BUBBLE(obs[0][3]),
        .EX_MEM_WE(obs[0][2]), .EX_MEM_BUBBLE(obs[0][1]),
`ifdef HAZ_PERF_CNT_EN
        .LU_STALL_CNT(lu_c[0]), .MD_STALL_CNT(md_c[0]), .MEM_STALL_CNT(mem_c[0]),
`endif
        .MEM_WB_BUBBLE(obs[0][0]));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYC(3), .MULDIV_CYC(2)) dut1 (
        .CLK(clk), .RESET(rst), .ID_ADDR1(a1), .ID_ADDR2(a2), .ID_OP1_SEL(op1), .ID_OP2_SEL(op2),
        .ID_VALID(vld), .EX_W_ADDR(wa), .EX_MEM_READ(mr), .EX_MULDIV(md), .MEM_BUSY(busy),
        .PC_WE(obs[1][6]), .IF_ID_WE(obs[1][5]), .ID_EX_WE(obs[1][4]), .ID_EX_BUBBLE(obs[1][3]),
        .EX_MEM_WE(obs[1][2]), .EX_MEM_BUBBLE(obs[1][1]),
`ifdef HAZ_PERF_CNT_EN
        .LU_STALL_CNT(lu_c[1]), .MD_STALL_CNT(md_c[1]), .MEM_STALL_CNT(mem_c[1]),
`endif
        .MEM_WB_BUBBLE(obs[1][0]));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYC(2), .MULDIV_CYC(1)) dut2 (
        .CLK(clk), .RESET(rst), .ID_ADDR1(a1), .ID_ADDR2(a2), .ID_OP1_SEL(op1), .ID_OP2_SEL(op2),
        .ID_VALID(vld), .EX_W_ADDR(wa), .EX_MEM_READ(mr), .EX_MULDIV(md), .MEM_BUSY(busy),
        .PC_WE(obs[2][6]), .IF_ID_WE(obs[2][5]), .ID_EX_WE(obs[2][4]), .ID_EX_BUBBLE(obs[2][3]),
        .EX_MEM_WE(obs[2][2]), .EX_MEM_BUBBLE(obs[2][1]),
`ifdef HAZ_PERF_CNT_EN
        .LU_STALL_CNT(lu_c[2]), .MD_STALL_CNT(md_c[2]), .MEM_STALL_CNT(mem_c[2]),
`endif
        .MEM_WB_BUBBLE(obs[2][0]));

    function automatic logic [6:0] model(input int k);
        bit lu;
        lu = vld && mr && (wa != 0) && ((!op1 && a1 == wa) || (!op2 && a2 == wa));
        n_md[k]  = md_left[k];
        n_lu[k]  = lu_left[k];
        n_rel[k] = rel[k];
        if (rst) begin
            n_md[k] = 0; n_lu[k] = 0; n_rel[k] = 0;
            return RST_V;
        end
        if (busy) return MEM_V;
        if (md_left[k] > 0) begin
            n_md[k] = md_left[k] - 1;
            return MD_V;
        end
        if (rel[k]) begin
            n_rel[k] = 0;
            return IDLE_V;
        end
        if (lu_left[k] > 0) begin
            n_lu[k] = lu_left[k] - 1;
            return LU_V;
        end
        if (md && mcyc[k] > 1) begin
            // MULDIV_CYC-1 freeze cycles in total, then one release cycle if a wait state was entered
            n_md[k]  = mcyc[k] - 2;
            n_rel[k] = (mcyc[k] > 2);
            return MD_V;
        end
        if (lu) begin
            n_lu[k] = lcyc[k] - 1;
            return LU_V;
        end
        return IDLE_V;
    endfunction

    task automatic step(input logic r, input logic v, input int x1, input int x2,
                        input logic s1, input logic s2, input int w,
                        input logic m_rd, input logic m_md, input logic m_busy);
        logic [6:0] exp_v;
        rst = r; vld = v; a1 = 5'(x1); a2 = 5'(x2); op1 = s1; op2 = s2;
        wa = 5'(w); mr = m_rd; md = m_md; busy = m_busy;
        #4;
        for (int k = 0; k < 3; k++) begin
            exp_v = model(k);
            n_cmp++;
            assert (obs[k] === exp_v) else begin
                n_err++;
                $error("FAIL outputs dut%0d cyc%0d observed=%b expected=%b", k, cyc, obs[k], exp_v);
            end
`ifdef HAZ_PERF_CNT_EN
            if (r) begin
                exp_lu[k] = 0; exp_md[k] = 0; exp_mem[k] = 0;
            end else begin
                if (exp_v == LU_V)  exp_lu[k]++;
                if (exp_v == MD_V)  exp_md[k]++;
                if (exp_v == MEM_V) exp_mem[k]++;
            end
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            md_left[k] = n_md[k];
            lu_left[k] = n_lu[k];
            rel[k]     = n_rel[k];
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 7, 8, 0, 0, 9, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(1, 1, 2, 2, 0, 0, 2, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // lw x2 in EX, add rs2=x2 in ID
        step(0, 1, 5, 2, 0, 0, 2, 1, 0, 0);
        step(0, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        idle(4);

        // x0 destination and operand-not-from-regfile never stall
        step(0, 1, 0, 3, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2, 3, 1, 0, 2, 1, 0, 0);
        step(0, 0, 2, 2, 0, 0, 2, 1, 0, 0);
        idle(2);

        // rs1 dependency held across a long load-use stall
        step(0, 1, 6, 1, 0, 1, 6, 1, 0, 0);
        step(0, 1, 6, 1, 0, 1, 6, 0, 0, 0);
        step(0, 1, 6, 1, 0, 1, 6, 0, 0, 0);
        idle(3);

        // MUL/DIV held in EX with a two-cycle memory wait inside the freeze
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 1);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 1);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        idle(3);

        // Reset during the second MUL/DIV wait cycle
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        step(1, 1, 1, 1, 0, 0, 3, 0, 1, 0);
        idle(4);

        // Illegal load + MUL/DIV with a matching operand: MUL/DIV wins
        step(0, 1, 4, 4, 0, 0, 4, 1, 1, 0);
        step(0, 1, 4, 4, 0, 0, 4, 1, 1, 0);
        step(0, 1, 4, 4, 0, 0, 4, 1, 1, 0);
        step(0, 1, 4, 4, 0, 0, 4, 1, 1, 0);
        idle(4);

        // Memory wait released straight into a load-use hazard
        step(0, 1, 3, 3, 0, 0, 3, 1, 0, 1);
        step(0, 1, 3, 3, 0, 0, 3, 1, 0, 0);
        idle(4);

        // Randomized traffic on a small register window to provoke frequent matches
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99) == 0, $urandom_range(9) < 8,
                 int'($urandom_range(3)), int'($urandom_range(3)),
                 $urandom_range(9) < 2, $urandom_range(9) < 2,
                 int'($urandom_range(3)),
                 $urandom_range(9) < 3, $urandom_range(9) < 1, $urandom_range(9) < 2);
        end

`ifdef HAZ_PERF_CNT_EN
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            assert (lu_c[k] === 32'(exp_lu[k]) && md_c[k] === 32'(exp_md[k]) && mem_c[k] === 32'(exp_mem[k])) else begin
                n_err++;
                $error("FAIL perf_cnt dut%0d observed=%0d/%0d/%0d expected=%0d/%0d/%0d",
                       k, lu_c[k], md_c[k], mem_c[k], exp_lu[k], exp_md[k], exp_mem[k]);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
